spi_bus_arbiter: RTL and testbench

Shares one SPI master (SCLK/MOSI/MISO) between two on-board requesters: client 0 is the LAN controller and client 1 is the EPCS configuration flash. Each client requests a chip-select-framed burst of bytes. The block arbitrates between them, drives the granted client's active-low chip select, and shifts bytes in SPI mode 0, MSB first. It sits between the soft-CPU side peripherals and the board LAN_CS / epcs sce / SCLK / MOSI / MISO pins.

---
 rtl/spi_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// SPI master shared by two clients (0: LAN controller, 1: EPCS flash) with round-robin
// arbitration; one chip-select-framed burst per grant, mode 0, MSB first.
module spi_bus_arbiter #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] byte_valid,
    input  logic [1:0] byte_last,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] byte_ready,
    output logic [7:0] rx_data,
    output logic [1:0] rx_valid,
    output logic [1:0] grant,
    output logic [1:0] cs_n,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {IDLE, SETUP, WAIT_BYTE, SHIFT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [1:0]  rx_valid_q, rx_valid_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  cs_n_q, cs_n_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        served_q, served_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        pick;
    logic [7:0]  tx_sel;

    // On a tie the client not served last wins; served_q resets to 1 so client 0 goes first.
    assign pick   = (req == 2'b11) ? ~served_q : req[1];
    assign tx_sel = owner_q ? tx_data1 : tx_data0;

    assign byte_ready = (state_q == WAIT_BYTE) ? grant_q : 2'b00;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign grant      = grant_q;
    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= '0;
            grant_q    <= '0;
            cs_n_q     <= 2'b11;
            last_q     <= 1'b0;
            owner_q    <= 1'b0;
            served_q   <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            grant_q    <= grant_d;
            cs_n_q     <= cs_n_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            served_q   <= served_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 2'b00;
        grant_d    = grant_q;
        cs_n_d     = cs_n_q;
        last_d     = last_q;
        owner_d    = owner_q;
        served_d   = served_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_d = pick;
                    grant_d = pick ? 2'b10 : 2'b01;
                    cs_n_d  = pick ? 2'b01 : 2'b10;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 16'(CS_SETUP - 1)) state_d = WAIT_BYTE;
                else                            cnt_d   = cnt_q + 16'd1;
            end
            WAIT_BYTE: begin
                if (byte_valid[owner_q]) begin
                    tx_d    = tx_sel;
                    last_d  = byte_last[owner_q];
                    mosi_d  = tx_sel[7];
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Each half bit lasts CLK_DIV cycles; rise samples miso, fall advances mosi.
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rx_data_d  = rx_sh_q;
                            rx_valid_d = grant_q;
                            state_d    = last_q ? HOLD : WAIT_BYTE;
                        end else begin
                            mosi_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 16'(CS_HOLD - 1)) begin
                    cs_n_d   = 2'b11;
                    grant_d  = 2'b00;
                    served_d = owner_q;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: CLK_DIV=4 instance with miso looped to mosi,
// plus a CLK_DIV=1 instance with miso tied high.
module tb_spi_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req, byte_valid, byte_last;
    logic [7:0] tx_data0, tx_data1;
    logic [1:0] byte_ready, rx_valid, grant, cs_n;
    logic [7:0] rx_data;
    logic       sclk, mosi, miso;

    logic [1:0] req_b, bv_b, bl_b;
    logic [7:0] tx0_b, tx1_b;
    logic [1:0] ready_b, rxv_b, grant_b, cs_n_b;
    logic [7:0] rx_data_b;
    logic       sclk_b, mosi_b;
    logic       miso_b = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    assign miso = mosi;

    spi_bus_arbiter #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .byte_valid(byte_valid),
        .byte_last(byte_last), .tx_data0(tx_data0), .tx_data1(tx_data1),
        .byte_ready(byte_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .grant(grant), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    spi_bus_arbiter #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_div1 (
        .clk(clk), .reset_n(reset_n), .req(req_b), .byte_valid(bv_b),
        .byte_last(bl_b), .tx_data0(tx0_b), .tx_data1(tx1_b),
        .byte_ready(ready_b), .rx_data(rx_data_b), .rx_valid(rxv_b),
        .grant(grant_b), .cs_n(cs_n_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
    );

    // Monitor: free-running counters; the stimulus takes snapshots and differences.
    int         cyc = 0, cs0_low = 0, rises = 0, rxv0 = 0, rxv1 = 0;
    logic       prev_sclk = 1'b0, bad_cs = 1'b0, bad_rxv = 1'b0;
    logic [7:0] mosi_cap = '0;
    logic [31:0] rx0_hist = '0, rx1_hist = '0;
    int         b_rises = 0, b_r0 = 0, b_r1 = 0, b_rxv = 0, b_cs_low = 0;
    logic       prev_sclk_b = 1'b0;
    logic [7:0] b_rx = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cs_n[0] === 1'b0) cs0_low <= cs0_low + 1;
        prev_sclk <= sclk;
        if (sclk && !prev_sclk) begin
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[6:0], mosi};
        end
        if (rx_valid[0]) begin
            rxv0     <= rxv0 + 1;
            rx0_hist <= {rx0_hist[23:0], rx_data};
        end
        if (rx_valid[1]) begin
            rxv1     <= rxv1 + 1;
            rx1_hist <= {rx1_hist[23:0], rx_data};
        end
        if (cs_n === 2'b00) bad_cs <= 1'b1;
        if ((rx_valid & ~grant) != 2'b00) bad_rxv <= 1'b1;
        if (cs_n_b[0] === 1'b0) b_cs_low <= b_cs_low + 1;
        prev_sclk_b <= sclk_b;
        if (sclk_b && !prev_sclk_b) begin
            b_rises <= b_rises + 1;
            if (b_rises == 0) b_r0 <= cyc;
            if (b_rises == 1) b_r1 <= cyc;
        end
        if (rxv_b[0]) begin
            b_rxv <= b_rxv + 1;
            b_rx  <= rx_data_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int idx, input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (byte_ready[idx]) begin ok = 1'b1; break; end
            tick();
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (cs_n == 2'b11 && grant == 2'b00) begin ok = 1'b1; break; end
            tick();
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_grant_nz(input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (grant != 2'b00) begin ok = 1'b1; break; end
            tick();
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_grant_not(input logic [1:0] g, input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (grant != g) begin ok = 1'b1; break; end
            tick();
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    int snap_cs, snap_r, snap_v0, snap_v1, idle_n;
    bit ok_w;

    initial begin
        reset_n = 1'b0;
        req = '0; byte_valid = '0; byte_last = '0; tx_data0 = '0; tx_data1 = '0;
        req_b = '0; bv_b = '0; bl_b = '0; tx0_b = '0; tx1_b = '0;
        repeat (2) tick();
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_ready", byte_ready, 2'b00);
        check("rst_rx_valid", rx_valid, 2'b00);
        check("rst_rx_data", rx_data, 8'h00);
        reset_n = 1'b1;
        tick();

        // single byte 0xA5 from client 0
        snap_cs = cs0_low; snap_r = rises; snap_v0 = rxv0;
        req = 2'b01; byte_valid = 2'b01; byte_last = 2'b01; tx_data0 = 8'hA5;
        wait_ready(0, 20, "t1_ready");
        tick();
        byte_valid = '0; byte_last = '0; req = '0;
        wait_idle(200, "t1_idle");
        check("t1_cs0_low_cycles", cs0_low - snap_cs, 69);
        check("t1_sclk_rises", rises - snap_r, 8);
        check("t1_rx_valid_pulses", rxv0 - snap_v0, 1);
        check("t1_rx_byte", rx0_hist[7:0], 8'hA5);
        check("t1_rx_data", rx_data, 8'hA5);
        check("t1_mosi_bits", mosi_cap, 8'hA5);

        // simultaneous requests straight after reset
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        req = 2'b11; byte_valid = 2'b11; byte_last = 2'b11;
        tx_data0 = 8'h3C; tx_data1 = 8'hC3;
        wait_grant_nz(10, "t2_grant_wait");
        check("t2_first_grant", grant, 2'b01);
        wait_grant_not(2'b01, 200, "t2_release");
        idle_n = 0;
        while (grant == 2'b00 && idle_n < 10) begin idle_n++; tick(); end
        check("t2_idle_cycles", idle_n, 1);
        check("t2_second_grant", grant, 2'b10);
        check("t2_cs_second", cs_n, 2'b01);
        req = 2'b00;
        wait_idle(200, "t2_idle");
        byte_valid = '0; byte_last = '0;
        check("t2_rx0", rx0_hist[7:0], 8'h3C);
        check("t2_rx1", rx1_hist[7:0], 8'hC3);

        // client 1, three bytes with a gap before byte 2
        snap_v1 = rxv1;
        req = 2'b10; byte_valid = 2'b10; byte_last = 2'b00; tx_data1 = 8'h03;
        wait_ready(1, 20, "t3_ready0");
        tick();
        byte_valid = '0; req = '0;
        wait_ready(1, 200, "t3_ready1");
        snap_r = rises;
        repeat (5) tick();
        check("t3_gap_cs", cs_n, 2'b01);
        check("t3_gap_sclk", sclk, 1'b0);
        check("t3_gap_rises", rises - snap_r, 0);
        check("t3_gap_ready", byte_ready, 2'b10);
        tx_data1 = 8'h00; byte_valid = 2'b10;
        tick();
        byte_valid = '0;
        wait_ready(1, 200, "t3_ready2");
        tx_data1 = 8'h10; byte_last = 2'b10; byte_valid = 2'b10;
        tick();
        byte_valid = '0; byte_last = '0;
        wait_idle(200, "t3_idle");
        check("t3_rx_pulses", rxv1 - snap_v1, 3);
        check("t3_rx_bytes", rx1_hist[23:0], 24'h030010);

        // client 0 drops req mid-burst while client 1 requests
        req = 2'b01; byte_valid = 2'b01; byte_last = 2'b00; tx_data0 = 8'h11;
        wait_ready(0, 20, "t4_ready0");
        tick();
        byte_valid = '0; req = 2'b10;
        wait_ready(0, 200, "t4_ready1");
        check("t4_owner_kept", grant, 2'b01);
        check("t4_cs_kept", cs_n, 2'b10);
        tx_data0 = 8'h22; byte_last = 2'b01; byte_valid = 2'b01;
        tick();
        byte_valid = '0; byte_last = '0;
        wait_grant_not(2'b01, 200, "t4_release");
        wait_grant_nz(10, "t4_regrant");
        check("t4_waiting_client", grant, 2'b10);
        tx_data1 = 8'h5A; byte_last = 2'b10; byte_valid = 2'b10;
        wait_ready(1, 20, "t4_ready_c1");
        tick();
        byte_valid = '0; byte_last = '0; req = '0;
        wait_idle(200, "t4_idle");
        check("t4_rx0", rx0_hist[15:0], 16'h1122);
        check("t4_rx1", rx1_hist[7:0], 8'h5A);

        // asynchronous reset during bit 4 of a byte
        snap_r = rises; snap_v0 = rxv0;
        req = 2'b01; byte_valid = 2'b01; byte_last = 2'b01; tx_data0 = 8'h96;
        wait_ready(0, 20, "t5_ready");
        tick();
        byte_valid = '0; byte_last = '0; req = '0;
        ok_w = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rises - snap_r >= 4) begin ok_w = 1'b1; break; end
            tick();
        end
        check("t5_reach_bit4", {31'b0, ok_w}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_cs_n", cs_n, 2'b11);
        check("t5_async_sclk", sclk, 1'b0);
        check("t5_async_grant", grant, 2'b00);
        check("t5_async_ready", byte_ready, 2'b00);
        check("t5_async_mosi", mosi, 1'b0);
        repeat (3) tick();
        check("t5_no_partial", rxv0 - snap_v0, 0);
        reset_n = 1'b1;
        tick();
        req = 2'b01; byte_valid = 2'b01; byte_last = 2'b01; tx_data0 = 8'h5C;
        wait_ready(0, 20, "t5_ready_after");
        tick();
        byte_valid = '0; byte_last = '0; req = '0;
        wait_idle(200, "t5_idle");
        check("t5_rx_after", rx0_hist[7:0], 8'h5C);
        check("t5_rx_data_after", rx_data, 8'h5C);

        // CLK_DIV=1, miso tied high
        req_b = 2'b01; bv_b = 2'b01; bl_b = 2'b01; tx0_b = 8'h00;
        ok_w = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (b_rxv >= 1) begin ok_w = 1'b1; break; end
            tick();
        end
        check("t6_rx_seen", {31'b0, ok_w}, 32'd1);
        req_b = '0; bv_b = '0; bl_b = '0;
        repeat (4) tick();
        check("t6_rx_ff", b_rx, 8'hFF);
        check("t6_sclk_period", b_r1 - b_r0, 2);
        check("t6_rises", b_rises, 8);
        check("t6_cs_low_cycles", b_cs_low, 21);
        check("t6_cs_idle", cs_n_b, 2'b11);

        check("inv_cs_never_both_low", bad_cs, 1'b0);
        check("inv_rx_valid_owner", bad_rxv, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
